// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope capture controller.
package scope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST_FILL,
    DUMP_RD,
    DUMP_SEND,
    DUMP_GAP
  } state_e;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

  localparam int unsigned NCH_MAX = 4;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered 1-cycle read, no reset on contents.
module scope_capture_ram #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/scope_capture.sv
// Triggered capture of NCH ADC channels into a circular buffer, then a framed byte dump
// to the UART transmitter over its start/busy handshake.
module scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [NCH*DATA_W-1:0] adc_data,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic [1:0]            trig_ch,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  trig_edge,
  input  logic [ADDR_W-1:0]     pretrig,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  triggered
);

  localparam int unsigned            CH_W = $clog2(NCH_MAX);
  localparam logic [ADDR_W-1:0]      LAST = ADDR_W'((2 ** ADDR_W) - 1);

  state_e              r_state, r_state_d;
  logic [ADDR_W-1:0]   r_wr_ptr, r_wr_ptr_d, r_rd_ptr, r_rd_ptr_d, r_cnt, r_cnt_d;
  logic [ADDR_W-1:0]   r_pretrig, r_pretrig_d;
  logic [CH_W-1:0]     r_ch, r_ch_d;
  logic [1:0]          r_trig_ch, r_trig_ch_d;
  logic [DATA_W-1:0]   r_prev, r_prev_d, r_level, r_level_d;
  logic                r_prev_valid, r_prev_valid_d, r_edge, r_edge_d;
  logic [7:0]          r_tx_data, r_tx_data_d;
  logic                r_tx_start, r_tx_start_d, r_triggered, r_triggered_d;

  logic                w_we, w_re, w_fire;
  logic [DATA_W-1:0]   w_cur;
  logic [7:0]          w_byte;
  logic [NCH*DATA_W-1:0] w_rd_word;

  scope_capture_ram #(
    .WIDTH  (NCH * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (adc_data),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_word)
  );

  always_comb begin
    w_cur  = '0;
    w_byte = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(r_trig_ch) == k) w_cur  = adc_data[k*DATA_W +: DATA_W];
      if (32'(r_ch) == k)      w_byte = w_rd_word[k*DATA_W +: 8];
    end
  end

  // prev is only ever updated with non-trigger samples, so it is always the preceding sample
  assign w_fire = force_trig ||
                  (r_prev_valid &&
                   (((r_edge == TRIG_RISING)  && (r_prev < r_level) && (w_cur >= r_level)) ||
                    ((r_edge == TRIG_FALLING) && (r_prev > r_level) && (w_cur <= r_level))));

  always_comb begin
    r_state_d      = r_state;
    r_wr_ptr_d     = r_wr_ptr;
    r_rd_ptr_d     = r_rd_ptr;
    r_cnt_d        = r_cnt;
    r_pretrig_d    = r_pretrig;
    r_ch_d         = r_ch;
    r_trig_ch_d    = r_trig_ch;
    r_prev_d       = r_prev;
    r_level_d      = r_level;
    r_prev_valid_d = r_prev_valid;
    r_edge_d       = r_edge;
    r_tx_data_d    = r_tx_data;
    r_tx_start_d   = 1'b0;
    r_triggered_d  = r_triggered;
    w_we           = 1'b0;
    w_re           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (arm) begin
          r_pretrig_d    = pretrig;
          r_trig_ch_d    = (32'(trig_ch) < NCH) ? trig_ch : 2'd0;
          r_level_d      = trig_level;
          r_edge_d       = trig_edge;
          r_wr_ptr_d     = '0;
          r_cnt_d        = '0;
          r_prev_valid_d = 1'b0;
          r_state_d      = (pretrig != '0) ? PRE_FILL : WAIT_TRIG;
        end
      end
      PRE_FILL: begin
        if (sample_en) begin
          w_we           = 1'b1;
          r_wr_ptr_d     = r_wr_ptr + 1'b1;
          r_cnt_d        = r_cnt + 1'b1;
          r_prev_d       = w_cur;
          r_prev_valid_d = 1'b1;
          if (r_cnt + 1'b1 == r_pretrig) r_state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (sample_en) begin
          w_we       = 1'b1;
          r_wr_ptr_d = r_wr_ptr + 1'b1;
          if (w_fire) begin
            r_triggered_d = 1'b1;
            if (r_pretrig == LAST) begin
              r_rd_ptr_d = r_wr_ptr + 1'b1;
              r_cnt_d    = '0;
              r_state_d  = DUMP_RD;
            end else begin
              r_cnt_d   = LAST - r_pretrig;
              r_state_d = POST_FILL;
            end
          end else begin
            r_prev_d       = w_cur;
            r_prev_valid_d = 1'b1;
          end
        end
      end
      POST_FILL: begin
        if (sample_en) begin
          w_we       = 1'b1;
          r_wr_ptr_d = r_wr_ptr + 1'b1;
          r_cnt_d    = r_cnt - 1'b1;
          if (r_cnt == ADDR_W'(1)) begin
            r_rd_ptr_d = r_wr_ptr + 1'b1;
            r_cnt_d    = '0;
            r_state_d  = DUMP_RD;
          end
        end
      end
      DUMP_RD: begin
        w_re      = 1'b1;
        r_ch_d    = '0;
        r_state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (!tx_busy) begin
          r_tx_data_d  = w_byte;
          r_tx_start_d = 1'b1;
          r_state_d    = DUMP_GAP;
        end
      end
      DUMP_GAP: begin
        if (32'(r_ch) != NCH - 1) begin
          r_ch_d    = r_ch + 1'b1;
          r_state_d = DUMP_SEND;
        end else begin
          r_rd_ptr_d = r_rd_ptr + 1'b1;
          if (r_cnt == LAST) begin
            r_triggered_d = 1'b0;
            r_state_d     = IDLE;
          end else begin
            r_cnt_d   = r_cnt + 1'b1;
            r_state_d = DUMP_RD;
          end
        end
      end
      default: r_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_pretrig    <= '0;
      r_ch         <= '0;
      r_trig_ch    <= '0;
      r_prev       <= '0;
      r_level      <= '0;
      r_prev_valid <= 1'b0;
      r_edge       <= 1'b0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_triggered  <= 1'b0;
    end else begin
      r_state      <= r_state_d;
      r_wr_ptr     <= r_wr_ptr_d;
      r_rd_ptr     <= r_rd_ptr_d;
      r_cnt        <= r_cnt_d;
      r_pretrig    <= r_pretrig_d;
      r_ch         <= r_ch_d;
      r_trig_ch    <= r_trig_ch_d;
      r_prev       <= r_prev_d;
      r_level      <= r_level_d;
      r_prev_valid <= r_prev_valid_d;
      r_edge       <= r_edge_d;
      r_tx_data    <= r_tx_data_d;
      r_tx_start   <= r_tx_start_d;
      r_triggered  <= r_triggered_d;
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign busy      = (r_state != IDLE);
  assign triggered = r_triggered;

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench: a frame-level reference model queues expected dump bytes per capture,
// a monitor pops and compares on every tx_start.
module tb_scope_capture;

  localparam int NCH = 2;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 16;
  localparam int LEN = 64;

  logic        clk = 1'b0, rst = 1'b1;
  logic        sample_en = 1'b0, arm = 1'b0, force_trig = 1'b0, trig_edge = 1'b0;
  logic [15:0] adc_data = '0;
  logic [1:0]  trig_ch = '0;
  logic [7:0]  trig_level = '0, tx_data;
  logic [3:0]  pretrig = '0;
  logic        tx_start, tx_busy, busy, triggered;

  int n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx[$];
  logic [15:0] smp[LEN];
  bit          frc[LEN];
  int          busy_cnt;

  scope_capture #(.NCH(NCH), .DATA_W(8), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .adc_data   (adc_data),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_ch    (trig_ch),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .pretrig    (pretrig),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  // UART transmitter stand-in: busy for 10 cycles after each start
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0);

  task automatic chk(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  logic [7:0] last_data;
  logic       last_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        chk("start_while_busy", int'(tx_busy), 0);
        if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
        else chk("dump_byte", int'(tx_data), int'(exp_q.pop_front()));
        rx.push_back(tx_data);
      end
      if (tx_busy && last_busy) chk("tx_data_stable", int'(tx_data), int'(last_data));
    end
    last_data = tx_data;
    last_busy = tx_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger = first sample at or after index p that is forced or crosses the level
  // relative to the sample before it.
  function automatic int find_trig(int p, int ch, logic [7:0] lvl, logic edg);
    logic [7:0] a, b;
    for (int i = p; i < LEN; i++) begin
      if (frc[i]) return i;
      if (i > 0) begin
        a = smp[i-1][8*ch +: 8];
        b = smp[i][8*ch +: 8];
        if (!edg && a < lvl && b >= lvl) return i;
        if (edg && a > lvl && b <= lvl) return i;
      end
    end
    return -1;
  endfunction

  task automatic run_capture(int p, int tch, logic [7:0] lvl, logic edg,
                             bit arm_with_sample, bit arm_in_dump, bit do_reset);
    int t, need, ch_eff;
    ch_eff = (tch < NCH) ? tch : 0;
    t = find_trig(p, ch_eff, lvl, edg);
    if (t < 0) begin
      chk("model_no_trigger", t, 0);
      return;
    end
    need = t + DEPTH - p;
    rx.delete();
    for (int k = t - p; k < t - p + DEPTH; k++) begin
      exp_q.push_back(smp[k][7:0]);
      exp_q.push_back(smp[k][15:8]);
    end
    pretrig = 4'(p); trig_ch = 2'(tch); trig_level = lvl; trig_edge = edg;
    arm = 1'b1;
    if (arm_with_sample) begin
      sample_en = 1'b1;
      adc_data  = 16'hFFFF;
    end
    tick();
    arm = 1'b0; sample_en = 1'b0;
    for (int i = 0; i < need + 3 && i < LEN; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      adc_data = smp[i]; force_trig = frc[i]; sample_en = 1'b1;
      tick();
      sample_en = 1'b0; force_trig = 1'b0;
    end
    for (int c = 0; c < 2000 && rx.size() < 1; c++) tick();
    chk("triggered_in_dump", int'(triggered), 1);
    chk("busy_in_dump", int'(busy), 1);
    if (do_reset) begin
      for (int c = 0; c < 2000 && !(rx.size() >= 5 && tx_busy); c++) tick();
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_triggered", int'(triggered), 0);
      chk("rst_tx_start", int'(tx_start), 0);
      tick();
      rst = 1'b0;
      exp_q.delete();
      tick();
      return;
    end
    if (arm_in_dump) begin
      arm = 1'b1;
      tick();
      arm = 1'b0;
    end
    for (int c = 0; c < 4000 && busy; c++) tick();
    chk("done_busy", int'(busy), 0);
    chk("done_triggered", int'(triggered), 0);
    chk("frame_len", rx.size(), 2 * DEPTH);
    chk("queue_empty", exp_q.size(), 0);
    repeat (12) tick();
  endtask

  task automatic fill_ramp(int start, int step);
    logic [7:0] v;
    for (int i = 0; i < LEN; i++) begin
      v = 8'(start + step * i);
      smp[i] = {~v, v};
      frc[i] = 1'b0;
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_triggered", int'(triggered), 0);
    chk("reset_tx_start", int'(tx_start), 0);
    chk("reset_tx_data", int'(tx_data), 0);
    rst = 1'b0;
    tick();

    // Rising ramp; arm coincides with a sample that must not be recorded
    fill_ramp(0, 16);
    run_capture(4, 0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rise_first", int'(rx[0]), 8'h40);
    chk("rise_trig_ch0", int'(rx[8]), 8'h80);
    chk("rise_trig_ch1", int'(rx[9]), 8'h7F);

    // Falling ramp from 0xF0
    fill_ramp(8'hF0, -16);
    run_capture(4, 0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fall_trig_ch0", int'(rx[8]), 8'h80);

    // Forced trigger, no pre-trigger
    for (int i = 0; i < LEN; i++) begin
      smp[i] = 16'hAA55;
      frc[i] = 1'b1;
    end
    run_capture(0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("force_first", int'(rx[0]), 8'h55);
    chk("force_second", int'(rx[1]), 8'hAA);
    chk("force_last", int'(rx[31]), 8'hAA);

    // Maximum pre-trigger: trigger sample is the last one dumped
    fill_ramp(0, 8);
    run_capture(15, 0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clamp_trig_ch0", int'(rx[30]), 8'h80);
    chk("clamp_trig_ch1", int'(rx[31]), 8'h7F);

    // Reset mid-dump, then a clean frame
    fill_ramp(0, 16);
    run_capture(4, 1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    run_capture(4, 0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_first", int'(rx[0]), 8'h40);

    // Randomized captures; a late forced sample guarantees termination
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < LEN; i++) begin
        smp[i] = 16'($urandom);
        frc[i] = ($urandom_range(0, 49) == 0);
      end
      frc[40] = 1'b1;
      run_capture($urandom_range(0, 15), $urandom_range(0, 3), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r == 5, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
